// File: rtl/rhythm_game_sequencer_if.sv
// Key inputs and sequencer status/strobe outputs shared between the game
// sequencer (master) and the datapath, VGA and HEX logic that consume them (slave).
interface rhythm_game_sequencer_if;
    logic       start_n;
    logic       pause_n;
    logic       load_map;
    logic       shift_tick;
    logic       playing;
    logic       counting_in;
    logic [3:0] cd_remaining;
    logic [7:0] beat_idx;
    logic       game_over;
    logic [2:0] state;

    modport master (
        input  start_n, pause_n,
        output load_map, shift_tick, playing, counting_in,
               cd_remaining, beat_idx, game_over, state
    );

    modport slave (
        output start_n, pause_n,
        input  load_map, shift_tick, playing, counting_in,
               cd_remaining, beat_idx, game_over, state
    );
endinterface

// File: rtl/rhythm_game_sequencer.sv
// Rhythm game sequencer: one FSM in the clk domain that drives map load,
// count-in, play, pause and game-over, and emits single-cycle shift strobes
// from an internal beat divider so downstream logic runs on clk enables only.
module rhythm_game_sequencer #(
    parameter int TICK_DIV        = 6250000,
    parameter int DIV_W           = 23,
    parameter int MAP_LEN         = 191,
    parameter int COUNTDOWN_BEATS = 8
) (
    input logic                     clk,
    input logic                     rst,
    rhythm_game_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_COUNTDOWN = 3'd2,
        S_PLAY      = 3'd3,
        S_PAUSE     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
    localparam logic [7:0]       BEAT_LAST = 8'(MAP_LEN - 1);
    localparam logic [3:0]       CD_INIT   = 4'(COUNTDOWN_BEATS);

    // Kept as a plain vector so the unused encodings 6 and 7 stay representable.
    logic [2:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       beat_q, beat_d;
    logic [3:0]       cd_q, cd_d;

    // Two-stage synchronizers plus a delayed copy for falling-edge detection.
    logic start_s1_q, start_s1_d, start_s2_q, start_s2_d, start_prev_q, start_prev_d;
    logic pause_s1_q, pause_s1_d, pause_s2_q, pause_s2_d, pause_prev_q, pause_prev_d;

    logic start_press;
    logic pause_press;
    logic running;
    logic tick;

    // Press detection, beat tick and next-state/next-counter logic.
    always_comb begin
        start_s1_d   = bus.start_n;
        start_s2_d   = start_s1_q;
        start_prev_d = start_s2_q;
        pause_s1_d   = bus.pause_n;
        pause_s2_d   = pause_s1_q;
        pause_prev_d = pause_s2_q;

        start_press = start_prev_q & ~start_s2_q;
        pause_press = pause_prev_q & ~pause_s2_q;

        running = (state_q == S_COUNTDOWN) || (state_q == S_PLAY);
        tick    = running && (div_q == DIV_LAST);

        state_d = state_q;
        beat_d  = beat_q;
        cd_d    = cd_q;

        // Divider advances while running, freezes in PAUSE, clears elsewhere.
        if (running) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end else if (state_q == S_PAUSE) begin
            div_d = div_q;
        end else begin
            div_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_press) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_COUNTDOWN;
                div_d   = '0;
                beat_d  = '0;
                cd_d    = CD_INIT;
            end
            S_COUNTDOWN: begin
                if (tick) begin
                    cd_d = cd_q - 4'd1;
                    if (cd_q == 4'd1) begin
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                // A non-final tick is always counted, whatever the keys do.
                if (tick) begin
                    beat_d = (beat_q == 8'hFF) ? beat_q : beat_q + 8'd1;
                end
                if (tick && (beat_q == BEAT_LAST)) begin
                    state_d = S_DONE;
                end else if (start_press) begin
                    state_d = S_IDLE;
                end else if (pause_press) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start_press) begin
                    state_d = S_IDLE;
                end else if (pause_press) begin
                    state_d = S_PLAY;
                end
            end
            S_DONE: begin
                if (start_press) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and key synchronizers; reset releases keys and idles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            beat_q       <= '0;
            cd_q         <= '0;
            start_s1_q   <= 1'b1;
            start_s2_q   <= 1'b1;
            start_prev_q <= 1'b1;
            pause_s1_q   <= 1'b1;
            pause_s2_q   <= 1'b1;
            pause_prev_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            beat_q       <= beat_d;
            cd_q         <= cd_d;
            start_s1_q   <= start_s1_d;
            start_s2_q   <= start_s2_d;
            start_prev_q <= start_prev_d;
            pause_s1_q   <= pause_s1_d;
            pause_s2_q   <= pause_s2_d;
            pause_prev_q <= pause_prev_d;
        end
    end

    assign bus.load_map     = (state_q == S_LOAD);
    assign bus.shift_tick   = (state_q == S_PLAY) && (div_q == DIV_LAST);
    assign bus.playing      = (state_q == S_PLAY);
    assign bus.counting_in  = (state_q == S_COUNTDOWN);
    assign bus.cd_remaining = (state_q == S_COUNTDOWN) ? cd_q : 4'd0;
    assign bus.beat_idx     = beat_q;
    assign bus.game_over    = (state_q == S_DONE);
    assign bus.state        = state_q;

endmodule

// File: tb/tb_rhythm_game_sequencer.sv
// Bench for rhythm_game_sequencer: directed and random key presses, a
// behavioural reference model that predicts strobes and status changes into a
// scoreboard, and an independent monitor that checks what the DUT presents.
module tb_rhythm_game_sequencer;
    localparam int T   = 4;
    localparam int ML  = 5;
    localparam int CDB = 2;

    localparam int M_IDLE = 0, M_LOAD = 1, M_CD = 2, M_PLAY = 3, M_PAUSE = 4, M_DONE = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    rhythm_game_sequencer_if bus ();

    rhythm_game_sequencer #(
        .TICK_DIV(T), .DIV_W(3), .MAP_LEN(ML), .COUNTDOWN_BEATS(CDB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int st;
        int beat;
        int cd;
        int ld;
        int sh;
    } ev_t;

    ev_t sbq[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;

    // Reference model state (song-level view: mode, active cycles in phase, beats).
    int m_mode  = M_IDLE;
    int m_act   = 0;
    int m_beats = 0;
    int p_st    = M_IDLE;
    int p_cd    = 0;
    bit hs_s[$] = '{1'b1, 1'b1, 1'b1, 1'b1};
    bit hs_p[$] = '{1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        bus.start_n = 1'b1;
        bus.pause_n = 1'b1;
    end

    // Reference model: a key counts as pressed three edges after it is first sampled low.
    always @(posedge clk) begin : model
        bit  ps, pp, tk;
        int  ecd, eld, esh;
        ev_t e;
        cyc++;
        if (!rst) begin
            m_mode  = M_IDLE;
            m_act   = 0;
            m_beats = 0;
            hs_s    = '{1'b1, 1'b1, 1'b1, 1'b1};
            hs_p    = '{1'b1, 1'b1, 1'b1, 1'b1};
        end else begin
            hs_s.push_front(bus.start_n);
            hs_p.push_front(bus.pause_n);
            ps = hs_s[3] & ~hs_s[2];
            pp = hs_p[3] & ~hs_p[2];
            void'(hs_s.pop_back());
            void'(hs_p.pop_back());
            tk = (m_mode == M_CD || m_mode == M_PLAY) && (m_act % T == T - 1);
            case (m_mode)
                M_IDLE:  if (ps) m_mode = M_LOAD;
                M_LOAD:  begin m_mode = M_CD; m_act = 0; m_beats = 0; end
                M_CD: begin
                    if (tk && (m_act / T == CDB - 1)) begin
                        m_mode = M_PLAY;
                        m_act  = 0;
                    end else begin
                        m_act++;
                    end
                end
                M_PLAY: begin
                    m_act++;
                    if (tk) m_beats++;
                    if (tk && m_beats == ML) m_mode = M_DONE;
                    else if (ps) m_mode = M_IDLE;
                    else if (pp) m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (ps) m_mode = M_IDLE;
                    else if (pp) m_mode = M_PLAY;
                end
                M_DONE:  if (ps) m_mode = M_LOAD;
                default: m_mode = M_IDLE;
            endcase
        end
        eld = (m_mode == M_LOAD) ? 1 : 0;
        esh = (m_mode == M_PLAY && (m_act % T == T - 1)) ? 1 : 0;
        ecd = (m_mode == M_CD) ? (CDB - m_act / T) : 0;
        if (eld == 1 || esh == 1 || m_mode != p_st || ecd != p_cd) begin
            e.cyc  = cyc;
            e.st   = m_mode;
            e.beat = m_beats;
            e.cd   = ecd;
            e.ld   = eld;
            e.sh   = esh;
            sbq.push_back(e);
        end
        p_st = m_mode;
        p_cd = ecd;
    end

    // Monitor: whenever the DUT strobes or changes status, pop and compare.
    int d_pst = 0;
    int d_pcd = 0;
    always @(negedge clk) begin : monitor
        int  st, cd, bt, ld, sh, lv_ok;
        ev_t e;
        st = int'(bus.state);
        cd = int'(bus.cd_remaining);
        bt = int'(bus.beat_idx);
        ld = int'(bus.load_map);
        sh = int'(bus.shift_tick);
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            n_tests++;
            n_fail++;
            $display("FAIL sb_missed: expected event cyc=%0d st=%0d beat=%0d not presented, now cyc=%0d st=%0d",
                     e.cyc, e.st, e.beat, cyc, st);
        end
        if (ld == 1 || sh == 1 || st != d_pst || cd != d_pcd) begin
            n_tests++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected cyc=%0d: got st=%0d beat=%0d cd=%0d ld=%0d sh=%0d, expected no event",
                         cyc, st, bt, cd, ld, sh);
            end else begin
                e = sbq.pop_front();
                lv_ok = (int'(bus.playing) == (e.st == M_PLAY ? 1 : 0)) &&
                        (int'(bus.counting_in) == (e.st == M_CD ? 1 : 0)) &&
                        (int'(bus.game_over) == (e.st == M_DONE ? 1 : 0));
                if (e.cyc != cyc || e.st != st || e.beat != bt || e.cd != cd ||
                    e.ld != ld || e.sh != sh || lv_ok == 0) begin
                    n_fail++;
                    $display("FAIL sb_event: got cyc=%0d st=%0d beat=%0d cd=%0d ld=%0d sh=%0d lv=%0d, expected cyc=%0d st=%0d beat=%0d cd=%0d ld=%0d sh=%0d lv=1",
                             cyc, st, bt, cd, ld, sh, lv_ok, e.cyc, e.st, e.beat, e.cd, e.ld, e.sh);
                end
            end
        end
        d_pst = st;
        d_pcd = cd;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive a key low at the current negedge for 'hold' cycles; which=0 start, 1 pause.
    task automatic press(input int which, input int hold);
        if (which == 0) bus.start_n = 1'b0; else bus.pause_n = 1'b0;
        repeat (hold) @(negedge clk);
        bus.start_n = 1'b1;
        bus.pause_n = 1'b1;
    endtask

    task automatic wait_state(input string name, input int st, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (int'(bus.state) == st) found = 1'b1;
        end
        check(name, int'(bus.state), st);
    endtask

    task automatic wait_tick(input string name, input int beat_before, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.shift_tick && int'(bus.beat_idx) == beat_before) found = 1'b1;
        end
        check(name, int'(found), 1);
    endtask

    task automatic wait_beat(input string name, input int beat, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (int'(bus.beat_idx) == beat && int'(bus.state) == M_PLAY) found = 1'b1;
        end
        check(name, int'(found), 1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int loads;
        int which;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_state", int'(bus.state), M_IDLE);
        check("rst_load_map", int'(bus.load_map), 0);
        check("rst_shift_tick", int'(bus.shift_tick), 0);
        check("rst_levels", int'({bus.playing, bus.counting_in, bus.game_over}), 0);
        check("rst_cd", int'(bus.cd_remaining), 0);
        check("rst_beat", int'(bus.beat_idx), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain song: start press reaches LOAD on the third edge
        press(0, 1);
        @(negedge clk);
        check("pre_load_state", int'(bus.state), M_IDLE);
        @(negedge clk);
        check("load_state", int'(bus.state), M_LOAD);
        check("load_pulse", int'(bus.load_map), 1);
        @(negedge clk);
        check("countdown_cd", int'(bus.cd_remaining), CDB);
        check("load_pulse_end", int'(bus.load_map), 0);
        wait_state("song1_done", M_DONE, 100);
        check("song1_beat", int'(bus.beat_idx), ML);
        check("song1_game_over", int'(bus.game_over), 1);
        repeat (10) @(negedge clk);
        check("done_holds_beat", int'(bus.beat_idx), ML);

        // Replay from DONE, pause coinciding with non-final then final tick
        press(0, 1);
        wait_tick("tick_beat0", 0, 100);
        repeat (2) @(negedge clk);
        press(1, 1);
        repeat (2) @(negedge clk);
        check("pause_on_tick_state", int'(bus.state), M_PAUSE);
        check("pause_on_tick_beat", int'(bus.beat_idx), 2);
        repeat (20) @(negedge clk);
        check("paused_beat_frozen", int'(bus.beat_idx), 2);
        check("paused_state", int'(bus.state), M_PAUSE);
        press(1, 1);
        wait_tick("tick_beat3", 3, 100);
        repeat (2) @(negedge clk);
        press(1, 1);
        repeat (2) @(negedge clk);
        check("final_tick_beats_pause", int'(bus.state), M_DONE);
        check("final_tick_beat", int'(bus.beat_idx), ML);

        // Random key activity, checked by the scoreboard
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(1, 12)) @(negedge clk);
            which = ($urandom_range(0, 7) == 0 || bus.state == 3'd0 || bus.state == 3'd5) ? 0 : 1;
            press(which, $urandom_range(1, 3));
        end

        // Reset mid-PLAY at beat 3 with start held low throughout
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        press(0, 1);
        wait_beat("reach_beat3", 3, 100);
        rst = 1'b0;
        bus.start_n = 1'b0;
        @(negedge clk);
        check("midrst_state", int'(bus.state), M_IDLE);
        check("midrst_beat", int'(bus.beat_idx), 0);
        check("midrst_outs", int'({bus.load_map, bus.shift_tick, bus.playing,
                                   bus.counting_in, bus.game_over, bus.cd_remaining}), 0);
        rst = 1'b1;
        loads = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.load_map) loads++;
        end
        bus.start_n = 1'b1;
        check("held_start_one_load", loads, 1);
        wait_state("song_after_rst_done", M_DONE, 200);

        // Unused encoding recovers to IDLE
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        force dut.state_q = 3'd6;
        #1;
        release dut.state_q;
        @(posedge clk);
        #1;
        check("illegal_state_recover", int'(bus.state), M_IDLE);

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rhythm_game_sequencer.md
Name: rhythm_game_sequencer

Overview:
- Top-level game sequencer for the rhythm game.
- Replaces the free-running 8 Hz strobe and the two-state start/stop control with one synchronous FSM in the CLOCK_50 domain.
- Sequences the datapath through map load, count-in, play, pause and game-over.
- Issues single-cycle shift strobes, so the rhythm shifter, scoring and VGA logic all run on clk with enables, not on a derived clock.

Parameters:
- TICK_DIV, 6250000: clk cycles per beat tick (50 MHz / 8 = 8 ticks/s); must be ≥2.
- DIV_W, 23: divider counter width; must satisfy 2^DIV_W ≥ TICK_DIV.
- MAP_LEN, 191: number of shift ticks in one song; range 1..256.
- COUNTDOWN_BEATS, 8: count-in ticks before play; range 1..15.

Ports:
- clk, in, 1: system clock (CLOCK_50).
- rst, in, 1: synchronous, active-low reset.
- start_n, in, 1: start/restart key, active-low, asynchronous to clk.
- pause_n, in, 1: pause/resume key, active-low, asynchronous to clk.
- load_map, out, 1: one-cycle pulse; datapath loads the rhythm map and clears score and combo.
- shift_tick, out, 1: one-cycle pulse; datapath shifts the map by one and judges.
- playing, out, 1: high in PLAY; gates button judging.
- counting_in, out, 1: high in COUNTDOWN.
- cd_remaining, out, 4: count-in ticks remaining; valid in COUNTDOWN, 0 otherwise.
- beat_idx, out, 8: shift ticks issued this song.
- game_over, out, 1: high in DONE.
- state, out, 3: encoded state for debug/HEX display.

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=IDLE; divider, beat_idx and cd_remaining = 0.
  - All pulse and level outputs = 0.
  - Synchronizer flops = 1 (keys released).
  - Reset overrides everything, including mid-song.
- Key input path:
  - Each key passes through a 2-FF synchronizer, then a falling-edge detector: press = prev_sync & ~sync.
  - The state register reacts on the 3rd rising edge after the key input falls.
  - Holding a key produces one press only.
- Divider:
  - Runs only in COUNTDOWN and PLAY; holds its value in PAUSE; forced to 0 in all other states.
  - tick = (divider == TICK_DIV-1); the divider wraps to 0 on that cycle.
  - All outputs decode from registers only; there is no combinational path from inputs.
- States and encoding:
  - IDLE = 0: on start press, go to LOAD.
  - LOAD = 1:
    - load_map=1 for exactly this one cycle.
    - Set divider=0, beat_idx=0, cd_remaining=COUNTDOWN_BEATS.
    - Next state is COUNTDOWN unconditionally.
  - COUNTDOWN = 2:
    - On tick, decrement cd_remaining.
    - On tick with cd_remaining==1, go to PLAY.
    - shift_tick stays 0. Presses are ignored.
  - PLAY = 3:
    - shift_tick = tick; beat_idx increments on each tick.
    - On tick with beat_idx==MAP_LEN-1, go to DONE; that final shift_tick is still issued and beat_idx reaches MAP_LEN.
    - A pause press goes to PAUSE.
    - A start press goes to IDLE (abort); beat_idx is held.
  - PAUSE = 4:
    - No ticks; divider and beat_idx are frozen.
    - A pause press returns to PLAY with the divider resuming from its held value.
    - A start press goes to IDLE.
  - DONE = 5:
    - game_over=1; beat_idx holds MAP_LEN.
    - A start press goes to LOAD, which restarts the song.
- Priority in PLAY when events coincide in one cycle:
  - final tick > start press > pause press.
  - A non-final tick is always emitted and counted, even when a press moves the state.
- Unused encodings 6 and 7 go to IDLE on the next clk.
- Widths: beat_idx is 8-bit unsigned and never wraps (MAP_LEN ≤ 256 stops at DONE). For MAP_LEN=256, beat_idx saturates at 255 in DONE.

Test Plan:
- Parameters for all scenarios: TICK_DIV=4, MAP_LEN=5, COUNTDOWN_BEATS=2.
- Reset, then start_n low for 1 cycle:
  - LOAD on the 3rd edge; load_map high exactly 1 cycle.
  - COUNTDOWN follows, with cd_remaining 2→1→0 at 4-cycle spacing.
  - PLAY entered on the 8th cycle of COUNTDOWN.
- Continue from the previous scenario:
  - 5 shift_tick pulses, 4 cycles apart, beat_idx 1..5.
  - DONE with game_over=1 on the cycle after the 5th pulse; no further shift_tick.
- Pause press after beat_idx=2, held 20 cycles, then a second press:
  - No shift_tick while paused; beat_idx stays 2.
  - First tick after resume arrives TICK_DIV minus the pre-pause divider progress cycles later.
- Pause press arriving on the same cycle as a non-final tick:
  - That tick is emitted, beat_idx increments, state becomes PAUSE.
  - With the final tick instead, the state becomes DONE.
- rst=0 asserted mid-PLAY at beat_idx=3:
  - Next cycle: IDLE, beat_idx=0, all outputs 0.
  - start_n held low continuously produces exactly one LOAD.
- In DONE, start press:
  - LOAD with load_map pulse; beat_idx=0; full song replays.
- Force state=6:
  - IDLE next cycle.
